// File: rtl/serial_adder_seq.sv
// serial_adder_seq
//    Bit-serial sequencer for an external combinational 1-bit full adder.
//    It accepts two WIDTH-bit operands and a carry-in on a start handshake.
//    It then adds them LSB first over WIDTH cycles. The sum and carry-out are
//    reported with a one-cycle done pulse.
//
// Ports
//    clk, rst_n       rising-edge clock, asynchronous active-low reset
//    start            operation request, sampled only in IDLE
//    abort            synchronous cancel, honoured only in RUN
//    op_a, op_b, cin  operands and carry-in, captured on accepted start
//    fa_a, fa_b       current operand bits presented to the full adder
//    fa_cin           stored carry presented to the full adder
//    fa_s, fa_cout    full-adder sum and carry, combinational from fa_*
//    busy             high while bits are being processed (RUN)
//    done             one-cycle pulse when sum/cout have just been updated
//    sum, cout        registered result, held until the next completion
module serial_adder_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_s,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, r_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      fa_a      = 1'b0;
      fa_b      = 1'b0;
      fa_cin    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy   = 1'b1;
            fa_a   = a_sh[0];
            fa_b   = b_sh[0];
            fa_cin = carry;
            // abort wins over the final-bit transition to DONE
            if (abort)            state_nxt = IDLE;
            else if (cnt == LAST) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         r_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= op_a;
                  b_sh  <= op_b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               if (!abort) begin
                  r_sh  <= {fa_s, r_sh[WIDTH-1:1]};
                  carry <= fa_cout;
                  a_sh  <= a_sh >> 1;
                  b_sh  <= b_sh >> 1;
                  cnt   <= cnt + CW'(1);
                  // Final bit: publish the result including the bit
                  // arriving this cycle.
                  if (cnt == LAST) begin
                     sum  <= {fa_s, r_sh[WIDTH-1:1]};
                     cout <= fa_cout;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
